// File: rtl/lcd_pkg.sv
// Shared constants and types for the HD44780 text refresher: init command bytes,
// DDRAM row base addresses and the transfer FSM state encoding.
package lcd_pkg;

    // Function set 8-bit/2-line, display on, clear, entry mode increment (step 0 in the low byte).
    localparam logic [31:0] INIT_SEQ  = {8'h06, 8'h01, 8'h0C, 8'h38};
    localparam logic [31:0] ROW_BASE  = {8'h54, 8'h14, 8'h40, 8'h00};
    localparam logic [7:0]  SET_DDRAM = 8'h80;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_DLY,
        S_NEXT
    } state_e;

    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        return INIT_SEQ[{step, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] row_cmd(input logic [1:0] row);
        return SET_DDRAM | ROW_BASE[{row, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/lcd_char_buffer.sv
// ROWS x COLS character store: range-checked write port with a registered error
// pulse, and an asynchronous read port used by the transfer sequencer.
module lcd_char_buffer #(
    parameter int COLS = 16,
    parameter int ROWS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [1:0] wr_row,
    input  logic [4:0] wr_col,
    input  logic [7:0] wr_char,
    input  logic [1:0] rd_row,
    input  logic [4:0] rd_col,
    output logic [7:0] rd_char,
    output logic       wr_ok,
    output logic       wr_err
);
    localparam logic [2:0] ROWS_L = 3'(ROWS);
    localparam logic [5:0] COLS_L = 6'(COLS);

    logic [7:0] mem_q [ROWS][COLS];
    logic [7:0] mem_d [ROWS][COLS];
    logic       wr_err_q, wr_err_d;
    logic       in_range;

    assign in_range = ({1'b0, wr_row} < ROWS_L) && ({1'b0, wr_col} < COLS_L);
    assign wr_ok    = wr_en & in_range;
    assign wr_err_d = wr_en & ~in_range;
    assign wr_err   = wr_err_q;

    always_comb begin
        mem_d = mem_q;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (wr_ok && wr_row == 2'(r) && wr_col == 5'(c)) begin
                    mem_d[r][c] = wr_char;
                end
            end
        end
    end

    always_comb begin
        rd_char = 8'h20;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (rd_row == 2'(r) && rd_col == 5'(c)) begin
                    rd_char = mem_q[r][c];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    mem_q[r][c] <= 8'h20;
                end
            end
            wr_err_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_err_q <= wr_err_d;
        end
    end

endmodule

// File: rtl/lcd_text_refresher.sv
// HD44780 text engine: runs the init sequence once after reset, then redraws the
// whole character buffer through the lcd_controller start/done handshake.
module lcd_text_refresher
    import lcd_pkg::*;
#(
    parameter int          COLS        = 16,
    parameter int          ROWS        = 2,
    parameter int unsigned DLY_CYCLES  = 262142,
    parameter int unsigned REFRESH_CYC = 100000000
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iWR_EN,
    input  logic [1:0] iWR_ROW,
    input  logic [4:0] iWR_COL,
    input  logic [7:0] iWR_CHAR,
    output logic       oWR_ERR,
    input  logic       iFORCE,
    output logic [7:0] oCTRL_DATA,
    output logic       oCTRL_RS,
    output logic       oCTRL_START,
    input  logic       iCTRL_DONE,
    output logic       oINIT_DONE,
    output logic       oBUSY
);
    localparam logic [31:0] DLY_LAST   = 32'(DLY_CYCLES - 1);
    localparam logic [31:0] TIMER_LAST = 32'(REFRESH_CYC - 1);
    localparam logic        REFRESH_ON = (REFRESH_CYC != 0);
    localparam logic [1:0]  ROWS_LAST  = 2'(ROWS - 1);
    localparam logic [4:0]  COLS_L     = 5'(COLS);

    state_e      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic [1:0]  row_q, row_d;
    logic [4:0]  pos_q, pos_d;
    logic [31:0] dly_q, dly_d;
    logic [31:0] timer_q, timer_d;
    logic        init_done_q, init_done_d;
    logic        dirty_q, dirty_d;
    logic        force_pend_q, force_pend_d;
    logic [7:0]  data_q, data_d;
    logic        rs_q, rs_d;
    logic        start_q, start_d;
    logic        busy_q, busy_d;

    logic        timer_hit, go, pass_start, wr_ok;
    logic [7:0]  rd_char;
    logic [4:0]  rd_col;

    // pos 0 of each row is the set-address command, so character column is pos-1.
    assign rd_col = pos_q - 5'd1;

    lcd_char_buffer #(.COLS(COLS), .ROWS(ROWS)) u_buf (
        .clk     (iCLK),
        .rst     (iRST),
        .wr_en   (iWR_EN),
        .wr_row  (iWR_ROW),
        .wr_col  (iWR_COL),
        .wr_char (iWR_CHAR),
        .rd_row  (row_q),
        .rd_col  (rd_col),
        .rd_char (rd_char),
        .wr_ok   (wr_ok),
        .wr_err  (oWR_ERR)
    );

    assign timer_hit  = REFRESH_ON && (timer_q == TIMER_LAST);
    assign go         = dirty_q | force_pend_q | timer_hit;
    // The post-reset init pass also counts as a pass start, so it consumes the reset-time dirty flag.
    assign pass_start = (state_q == S_IDLE && go) ||
                        (state_q == S_LOAD && !init_done_q && step_q == 2'd0);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q      <= S_LOAD;
            step_q       <= 2'd0;
            row_q        <= 2'd0;
            pos_q        <= 5'd0;
            dly_q        <= 32'd0;
            timer_q      <= 32'd0;
            init_done_q  <= 1'b0;
            dirty_q      <= 1'b1;
            force_pend_q <= 1'b0;
            data_q       <= 8'h00;
            rs_q         <= 1'b0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            row_q        <= row_d;
            pos_q        <= pos_d;
            dly_q        <= dly_d;
            timer_q      <= timer_d;
            init_done_q  <= init_done_d;
            dirty_q      <= dirty_d;
            force_pend_q <= force_pend_d;
            data_q       <= data_d;
            rs_q         <= rs_d;
            start_q      <= start_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        row_d       = row_q;
        pos_d       = pos_q;
        dly_d       = dly_q;
        init_done_d = init_done_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_LOAD;
                    row_d   = 2'd0;
                    pos_d   = 5'd0;
                end
            end
            S_LOAD: state_d = S_WAIT;
            S_WAIT: begin
                if (iCTRL_DONE) begin
                    state_d = S_DLY;
                    dly_d   = 32'd0;
                end
            end
            S_DLY: begin
                if (dly_q == DLY_LAST) state_d = S_NEXT;
                else                   dly_d   = dly_q + 32'd1;
            end
            S_NEXT: begin
                state_d = S_LOAD;
                if (!init_done_q) begin
                    if (step_q == 2'd3) begin
                        init_done_d = 1'b1;
                        row_d       = 2'd0;
                        pos_d       = 5'd0;
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end else if (pos_q == COLS_L) begin
                    if (row_q == ROWS_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        row_d = row_q + 2'd1;
                        pos_d = 5'd0;
                    end
                end else begin
                    pos_d = pos_q + 5'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        timer_d      = (!REFRESH_ON || timer_hit) ? 32'd0 : timer_q + 32'd1;
        // Set terms are OR-ed after the clear so a same-cycle request is never lost.
        dirty_d      = (dirty_q & ~pass_start) | wr_ok;
        force_pend_d = ((force_pend_q | timer_hit) & ~pass_start) | iFORCE;
    end

    always_comb begin
        data_d  = data_q;
        rs_d    = rs_q;
        start_d = (state_d == S_WAIT);
        busy_d  = (state_d != S_IDLE);
        if (state_q == S_LOAD) begin
            if (!init_done_q) begin
                data_d = init_cmd(step_q);
                rs_d   = 1'b0;
            end else if (pos_q == 5'd0) begin
                data_d = row_cmd(row_q);
                rs_d   = 1'b0;
            end else begin
                data_d = rd_char;
                rs_d   = 1'b1;
            end
        end
    end

    assign oCTRL_DATA  = data_q;
    assign oCTRL_RS    = rs_q;
    assign oCTRL_START = start_q;
    assign oINIT_DONE  = init_done_q;
    assign oBUSY       = busy_q;

endmodule

// File: tb/tb_lcd_text_refresher.sv
// Directed bench for lcd_text_refresher: a 2x16 instance driven through write, force
// and reset scenarios, plus a 4x20 instance with a 500-cycle periodic redraw.
module tb_lcd_text_refresher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_row = 2'd0;
    logic [4:0] wr_col = 5'd0;
    logic [7:0] wr_char = 8'h00;
    logic       force_a = 1'b0;

    logic       wr_err_a, rs_a, start_a, init_done_a, busy_a;
    logic [7:0] data_a;
    logic       done_a = 1'b0;

    logic       wr_en_b = 1'b0;
    logic [1:0] wr_row_b = 2'd0;
    logic [4:0] wr_col_b = 5'd0;
    logic [7:0] wr_char_b = 8'h00;
    logic       force_b = 1'b0;
    logic       wr_err_b, rs_b, start_b, init_done_b, busy_b;
    logic [7:0] data_b;
    logic       done_b = 1'b0;

    lcd_text_refresher #(.COLS(16), .ROWS(2), .DLY_CYCLES(4), .REFRESH_CYC(0)) dut_a (
        .iCLK(clk), .iRST(rst), .iWR_EN(wr_en), .iWR_ROW(wr_row), .iWR_COL(wr_col),
        .iWR_CHAR(wr_char), .oWR_ERR(wr_err_a), .iFORCE(force_a), .oCTRL_DATA(data_a),
        .oCTRL_RS(rs_a), .oCTRL_START(start_a), .iCTRL_DONE(done_a),
        .oINIT_DONE(init_done_a), .oBUSY(busy_a)
    );

    lcd_text_refresher #(.COLS(20), .ROWS(4), .DLY_CYCLES(4), .REFRESH_CYC(500)) dut_b (
        .iCLK(clk), .iRST(rst), .iWR_EN(wr_en_b), .iWR_ROW(wr_row_b), .iWR_COL(wr_col_b),
        .iWR_CHAR(wr_char_b), .oWR_ERR(wr_err_b), .iFORCE(force_b), .oCTRL_DATA(data_b),
        .oCTRL_RS(rs_b), .oCTRL_START(start_b), .iCTRL_DONE(done_b),
        .oINIT_DONE(init_done_b), .oBUSY(busy_b)
    );

    // Controller models: log {RS,DATA} once per START, pulse DONE 3 cycles after START rises.
    int         scnt_a = 0, scnt_b = 0;
    logic [8:0] log_a[$];
    logic [8:0] log_b[$];

    always @(posedge clk) begin
        if (!start_a) begin
            scnt_a <= 0;
            done_a <= 1'b0;
        end else begin
            if (scnt_a == 0) log_a.push_back({rs_a, data_a});
            scnt_a <= scnt_a + 1;
            done_a <= (scnt_a == 2);
        end
    end

    always @(posedge clk) begin
        if (!start_b) begin
            scnt_b <= 0;
            done_b <= 1'b0;
        end else begin
            if (scnt_b == 0) log_b.push_back({rs_b, data_b});
            scnt_b <= scnt_b + 1;
            done_b <= (scnt_b == 2);
        end
    end

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] mbuf [2][16];

    typedef struct {
        logic [1:0] row;
        logic [4:0] col;
        logic [7:0] ch;
        logic       err;
    } wvec_t;
    wvec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] at_a(input int i);
        if (i < log_a.size()) return log_a[i];
        return 9'h1FF;
    endfunction

    function automatic logic [8:0] at_b(input int i);
        if (i < log_b.size()) return log_b[i];
        return 9'h1FF;
    endfunction

    // Expected k-th transfer of a screen pass (no init) for the 2x16 instance.
    function automatic logic [8:0] exp_xfer(input int k);
        int row, pos;
        row = k / 17;
        pos = k % 17;
        if (pos == 0) return {1'b0, (row == 0) ? 8'h80 : 8'hC0};
        return {1'b1, mbuf[row][pos-1]};
    endfunction

    task automatic check_pass(input string name, input int base);
        for (int k = 0; k < 34; k++) begin
            chk($sformatf("%s xfer %0d", name, k + 1), 32'(at_a(base + k)), 32'(exp_xfer(k)));
        end
    endtask

    task automatic wait_log(input bit b, input int n, input int budget, input string name);
        int i;
        i = 0;
        while (((b ? log_b.size() : log_a.size()) < n) && i < budget) begin
            @(negedge clk);
            i++;
        end
        n_vec++;
        if ((b ? log_b.size() : log_a.size()) < n) begin
            n_err++;
            $display("FAIL %s: timeout with %0d transfers, expected %0d", name,
                     b ? log_b.size() : log_a.size(), n);
        end
    endtask

    task automatic wait_idle_a(input string name);
        int i;
        i = 0;
        while (busy_a && i < 50) begin
            @(negedge clk);
            i++;
        end
        chk(name, 32'(busy_a), 32'd0);
    endtask

    task automatic write_a(input logic [1:0] r, input logic [4:0] c, input logic [7:0] ch);
        @(negedge clk);
        wr_en = 1'b1; wr_row = r; wr_col = c; wr_char = ch;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_force;
        @(negedge clk);
        force_a = 1'b1;
        @(negedge clk);
        force_a = 1'b0;
    endtask

    task automatic clear_model;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 16; c++)
                mbuf[r][c] = 8'h20;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, base2;
        clear_model();
        tbl[0] = '{row: 2'd2, col: 5'd0,  ch: 8'h5A, err: 1'b1};
        tbl[1] = '{row: 2'd0, col: 5'd16, ch: 8'h5A, err: 1'b1};
        tbl[2] = '{row: 2'd1, col: 5'd15, ch: 8'h45, err: 1'b0};
        tbl[3] = '{row: 2'd3, col: 5'd31, ch: 8'h5A, err: 1'b1};
        tbl[4] = '{row: 2'd0, col: 5'd5,  ch: 8'h6D, err: 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset START", 32'(start_a), 32'd0);
        chk("reset BUSY", 32'(busy_a), 32'd0);
        chk("reset INIT_DONE", 32'(init_done_a), 32'd0);
        chk("reset WR_ERR", 32'(wr_err_a), 32'd0);
        chk("reset DATA", 32'(data_a), 32'd0);
        rst = 1'b0;

        // 1: init plus first full pass of spaces
        wait_log(1'b0, 38, 600, "t1 transfers");
        chk("t1 init0", 32'(at_a(0)), 32'h038);
        chk("t1 init1", 32'(at_a(1)), 32'h00C);
        chk("t1 init2", 32'(at_a(2)), 32'h001);
        chk("t1 init3", 32'(at_a(3)), 32'h006);
        check_pass("t1", 4);
        wait_idle_a("t1 busy low");
        chk("t1 INIT_DONE", 32'(init_done_a), 32'd1);
        repeat (30) @(negedge clk);
        chk("t1 no extra pass", 32'(log_a.size()), 32'd38);

        // 6: periodic redraw on the 4x20 instance
        wait_log(1'b1, 88 + 84, 3000, "t6 transfers");
        chk("t6 init0", 32'(at_b(0)), 32'h038);
        chk("t6 row0", 32'(at_b(4)), 32'h080);
        chk("t6 row1", 32'(at_b(25)), 32'h0C0);
        chk("t6 row2", 32'(at_b(46)), 32'h094);
        chk("t6 row3", 32'(at_b(67)), 32'h0D4);
        chk("t6 row3 last char", 32'(at_b(87)), 32'h120);
        chk("t6 p2 row0", 32'(at_b(88)), 32'h080);
        chk("t6 p2 row1", 32'(at_b(109)), 32'h0C0);
        chk("t6 p2 row2", 32'(at_b(130)), 32'h094);
        chk("t6 p2 row3", 32'(at_b(151)), 32'h0D4);

        // 2: one write in idle gives exactly one pass without init
        base = log_a.size();
        write_a(2'd1, 5'd3, 8'h41);
        mbuf[1][3] = 8'h41;
        wait_log(1'b0, base + 34, 600, "t2 transfers");
        chk("t2 transfer 22", 32'(at_a(base + 21)), 32'h141);
        check_pass("t2", base);
        wait_idle_a("t2 busy low");
        repeat (30) @(negedge clk);
        chk("t2 single pass", 32'(log_a.size()), 32'(base + 34));

        // 3: write during transfer 10 causes one further pass
        base = log_a.size();
        pulse_force();
        wait_log(1'b0, base + 10, 300, "t3 reach transfer 10");
        write_a(2'd0, 5'd0, 8'h58);
        wait_log(1'b0, base + 68, 1200, "t3 transfers");
        chk("t3 pass1 old char", 32'(at_a(base + 1)), 32'h120);
        mbuf[0][0] = 8'h58;
        chk("t3 pass2 first data", 32'(at_a(base + 35)), 32'h158);
        check_pass("t3 pass2", base + 34);
        wait_idle_a("t3 busy low");
        repeat (30) @(negedge clk);
        chk("t3 two passes", 32'(log_a.size()), 32'(base + 68));

        // 4: out-of-range writes pulse WR_ERR and start nothing
        base = log_a.size();
        write_a(2'd2, 5'd0, 8'h5A);
        chk("t4 err row", 32'(wr_err_a), 32'd1);
        write_a(2'd0, 5'd16, 8'h5A);
        chk("t4 err col", 32'(wr_err_a), 32'd1);
        @(negedge clk);
        chk("t4 err one cycle", 32'(wr_err_a), 32'd0);
        repeat (30) @(negedge clk);
        chk("t4 no pass", 32'(log_a.size()), 32'(base));
        chk("t4 idle", 32'(busy_a), 32'd0);

        for (int i = 0; i < 5; i++) begin
            write_a(tbl[i].row, tbl[i].col, tbl[i].ch);
            chk($sformatf("t4 vec %0d err", i), 32'(wr_err_a), 32'(tbl[i].err));
            if (!tbl[i].err) mbuf[tbl[i].row[0]][tbl[i].col[3:0]] = tbl[i].ch;
            @(negedge clk);
            chk($sformatf("t4 vec %0d err clear", i), 32'(wr_err_a), 32'd0);
        end
        wait_log(1'b0, base + 68, 1200, "t4 transfers");
        check_pass("t4 final", base + 34);
        wait_idle_a("t4 busy low");
        repeat (30) @(negedge clk);
        chk("t4 two passes", 32'(log_a.size()), 32'(base + 68));

        // 5: reset during S_WAIT of transfer 8 reruns init from scratch
        base = log_a.size();
        pulse_force();
        wait_log(1'b0, base + 8, 300, "t5 reach transfer 8");
        chk("t5 START before reset", 32'(start_a), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5 START dropped", 32'(start_a), 32'd0);
        chk("t5 INIT_DONE cleared", 32'(init_done_a), 32'd0);
        clear_model();
        base2 = log_a.size();
        wait_log(1'b0, base2 + 1, 20, "t5 restart");
        chk("t5 first after reset", 32'(at_a(base2)), 32'h038);
        chk("t5 INIT_DONE low in init", 32'(init_done_a), 32'd0);
        wait_log(1'b0, base2 + 38, 600, "t5 transfers");
        chk("t5 init3", 32'(at_a(base2 + 3)), 32'h006);
        check_pass("t5", base2 + 4);
        wait_idle_a("t5 busy low");
        chk("t5 INIT_DONE", 32'(init_done_a), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
